// File: rtl/apb_master_bridge.sv
// Single-outstanding command/response to APB master bridge.
// Each accepted command becomes one SETUP+ACCESS transfer with wait-state timeout.
module apb_master_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  // command/response side
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  // APB side
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  localparam bit          TimeoutEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TimeoutLast = TimeoutEn ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_rdata_d   = 32'd0;

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_addr[1:0] == 2'b00) begin
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
            pwrite_d = cmd_write;
            state_d  = StSetup;
          end else begin
            // Slaves ignore paddr[1:0], so misaligned requests never reach the bus.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      StSetup: begin
        cnt_d   = 16'd0;
        state_d = StAccess;
      end
      StAccess: begin
        if (pready) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = (!pwrite_q && !pslverr) ? prdata : 32'd0;
          state_d     = StIdle;
        end else if (TimeoutEn && (cnt_q == TimeoutLast)) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= 16'd0;
      paddr_q       <= 32'd0;
      pwdata_q      <= 32'd0;
      pwrite_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  // Bus strobes decode straight from state so reset clears them immediately.
  assign cmd_ready   = (state_q == StIdle);
  assign psel        = (state_q != StIdle);
  assign penable     = (state_q == StAccess);
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pwrite      = pwrite_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed vector bench for apb_master_bridge with an inline APB slave model.
module tb_apb_master_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata = 32'd0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  int n_vectors = 0;
  int n_checks = 0;
  int miscompares = 0;

  apb_master_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .paddr      (paddr),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;       // ACCESS cycles with pready=0 before the slave answers
    logic        slverr;
    int          exp_access;  // 0 means the bus must stay idle
    logic        exp_err;
    logic        exp_to;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    n_vectors++;
    chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    step();
    cmd_valid = 1'b0;
    cmd_addr  = 32'hFFFF_FFF0;
    cmd_wdata = 32'hFFFF_FFFF;
    if (v.exp_access == 0) begin
      chk("misal_psel", {31'd0, psel}, 32'd0);
    end else begin
      chk("setup_psel", {31'd0, psel}, 32'd1);
      chk("setup_penable", {31'd0, penable}, 32'd0);
      chk("setup_ready", {31'd0, cmd_ready}, 32'd0);
      chk("setup_pwrite", {31'd0, pwrite}, {31'd0, v.write});
      step();
      n = 0;
      while (psel && penable && n < 300) begin
        n++;
        chk("access_paddr", paddr, v.addr);
        if (v.write) chk("access_pwdata", pwdata, v.wdata);
        pready  = (n > v.waits);
        pslverr = v.slverr;
        prdata  = v.prdata;
        step();
      end
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = 32'd0;
      chk("access_cycles", n, v.exp_access);
      chk("end_psel", {31'd0, psel}, 32'd0);
      chk("end_penable", {31'd0, penable}, 32'd0);
    end
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
    chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, v.exp_to});
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    chk("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
    chk("rsp_err_clr", {31'd0, rsp_err}, 32'd0);
    chk("rdata_clr", rsp_rdata, 32'd0);
    chk("post_psel", {31'd0, psel}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //         wr    addr          wdata         prdata        wt    err  acc exp_err to    rdata
    vecs[0] = '{1'b1, 32'h4000_0004, 32'h0000_00A5, 32'hDEAD_BEEF, 0,    1'b0, 1, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h4000_0004, 32'h0,         32'h0000_00A5, 4,    1'b0, 5, 1'b0, 1'b0, 32'hA5};
    vecs[2] = '{1'b0, 32'h4000_0008, 32'h0,         32'h1234_5678, 1,    1'b1, 2, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 32'h4000_0010, 32'h0,         32'hCAFE_F00D, 1000, 1'b0, 8, 1'b1, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 32'h4000_0020, 32'h0000_55AA, 32'h0,         7,    1'b0, 8, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 32'h4000_0006, 32'h0,         32'h0,         0,    1'b0, 0, 1'b1, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 32'h4000_0001, 32'h1,         32'h0,         0,    1'b0, 0, 1'b1, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 32'h4000_00FC, 32'h0,         32'hFFFF_FFFF, 0,    1'b0, 1, 1'b0, 1'b0, 32'hFFFF_FFFF};
    vecs[8] = '{1'b1, 32'h4000_0040, 32'h0BAD_0001, 32'h0,         2,    1'b1, 3, 1'b1, 1'b0, 32'h0};

    step();
    step();
    chk("rst_psel", {31'd0, psel}, 32'd0);
    chk("rst_penable", {31'd0, penable}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset asserted during ACCESS: strobes drop at once and no response follows.
    n_vectors++;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h4000_0030;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("pre_rst_penable", {31'd0, penable}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_psel", {31'd0, psel}, 32'd0);
    chk("async_penable", {31'd0, penable}, 32'd0);
    chk("async_paddr", paddr, 32'd0);
    chk("async_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    step();
    chk("rst_no_rsp2", {31'd0, rsp_valid}, 32'd0);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, miscompares);
    $finish;
  end

endmodule
